syn_fifo_param: RTL
===================

Name: syn_fifo_param

Overview:
Parametrised synchronous single-clock FIFO. It is the successor of the fixed 8-bit syn_fifo and adds configurable width, depth and thresholds, plus occupancy count, almost-full/almost-empty flags, overflow/underflow pulses and a selectable first-word-fall-through read mode. It sits between any producer and consumer in the same clock domain.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
ADDR_W, $clog2(DEPTH), pointer width (derived; not overridden)
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH
AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset; asynchronous, active-high
wr_en  in  1  write request
wr_data  in  DATA_W  write data
rd_en  in  1  read request (FWFT=1: pop request)
rd_data  out  DATA_W  read data
rd_valid  out  1  rd_data holds a newly read word
fifo_full  out  1  count == DEPTH
fifo_empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
data_count  out  ADDR_W+1  current occupancy, 0..DEPTH
overflow  out  1  one-cycle pulse on a rejected write
underflow  out  1  one-cycle pulse on a rejected read

Behaviour:
- Reset (async assert, sync release): wr_ptr, rd_ptr, data_count = 0; fifo_empty = 1, almost_empty = 1; fifo_full, almost_full, rd_valid, overflow and underflow = 0; rd_data = 0 in FWFT=0 mode. Memory is not cleared. Reset mid-operation discards all contents immediately.
- rd_accept = rd_en && !fifo_empty.
- wr_accept = wr_en && (!fifo_full || rd_accept). A write to a full FIFO succeeds only if a read happens in the same cycle.
- Pointers are ADDR_W wide and wrap naturally from DEPTH-1 to 0. Occupancy is tracked by data_count: +1 on write only, -1 on read only, unchanged on both or neither.
- All flags are registered and computed from the next-state count. They are valid in the cycle after the edge that changed the count.
- Memory is read-first. A simultaneous read and write to the same address (the full case) returns the old word.
- FWFT=0: on rd_accept, rd_data is loaded with mem[rd_ptr] at the edge and rd_valid = 1 for the following cycle (latency 1). Otherwise rd_valid = 0 and rd_data holds its last value.
- FWFT=1: rd_data = mem[rd_ptr] combinationally and rd_valid = !fifo_empty. A word written into an empty FIFO appears on rd_data one cycle after the write edge. rd_en pops the word.
- Empty with simultaneous rd_en and wr_en: the read is rejected (underflow = 1), the write is accepted, and count becomes 1.
- Full with wr_en only: the write is rejected, overflow = 1, and the contents are unchanged.
- overflow and underflow are registered, last one cycle, and are not sticky.
- Elaboration check: DEPTH must be a power of two and AE_THRESH < AF_THRESH <= DEPTH. Otherwise $error.

Decomposition:
- Package syn_fifo_pkg holds a clog2 helper function, the default parameter constants, and a localparam check macro shared by future FIFO variants.
- Sub-module fifo_ram_dp: a DATA_W x DEPTH simple dual-port RAM (one write port, one read port) with a registered or combinational read selected by a parameter. Read-first semantics.
- Top level holds the pointers, count, flags and pulse logic.

Test Plan:
Bench parameters: DATA_W=8, DEPTH=8, AF_THRESH=6, AE_THRESH=1.
- Reset then idle: fifo_empty=1, almost_empty=1, data_count=0, every other output 0.
- Write 8 words 0x10..0x17, then a 9th write 0x99: data_count goes 1..8; almost_full asserts at count 6; fifo_full at 8; the 9th write gives overflow=1 for one cycle and count stays 8.
- With FWFT=0, read 8 words back: rd_data = 0x10..0x17, each with rd_valid one cycle after rd_en. A 9th rd_en gives underflow=1, rd_valid=0 and fifo_empty=1.
- At full (count 8), assert rd_en and wr_en (0xAA) together: rd_data = 0x10, count stays 8, no overflow. Draining later yields 0xAA last, which exercises pointer wrap.
- With FWFT=1, write 0x3C into an empty FIFO: rd_data = 0x3C and rd_valid = 1 the next cycle without rd_en. Pulsing rd_en gives fifo_empty=1.
- Assert rst asynchronously mid-stream with count 5: all outputs return to reset values immediately, without waiting for a clock edge. After release, a single write of 0x01 reads back 0x01.

Source files
------------

// File: rtl/syn_fifo_pkg.sv
// Shared constants and elaboration helpers for the synchronous FIFO family.
package syn_fifo_pkg;

   localparam int DEF_DATA_W    = 8;
   localparam int DEF_DEPTH     = 16;
   localparam int DEF_AE_THRESH = 1;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r = r + 1;
      return r;
   endfunction

   // Power-of-two depth keeps natural pointer wrap valid.
   function automatic bit fifo_cfg_ok(
      input int depth,
      input int ae,
      input int af
   );
      return (depth >= 2)
          && ((depth & (depth - 1)) == 0)
          && (ae < af)
          && (af <= depth);
   endfunction

endpackage

// File: rtl/syn_fifo_param_ram.sv
// Simple dual-port RAM, read-first, registered or combinational read port.
module fifo_ram_dp
   import syn_fifo_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int ADDR_W = clog2(DEPTH),
   parameter bit REG_RD = 1'b1
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   if (REG_RD) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
         if (rst) rdata <= '0;
         else if (re) rdata <= mem[raddr];
      end
   end else begin : g_comb
      logic unused_ctl;
      assign unused_ctl = rst ^ re;
      assign rdata = mem[raddr];
   end

endmodule

// File: rtl/syn_fifo_param.sv
// Parametrised single-clock FIFO: pointers, occupancy, flags, pulses.
module syn_fifo_param
   import syn_fifo_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int ADDR_W    = clog2(DEPTH),
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = DEF_AE_THRESH,
   parameter bit FWFT      = 1'b0
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              fifo_full,
   output logic              fifo_empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [ADDR_W:0]   data_count,
   output logic              overflow,
   output logic              underflow
);

   localparam int CW = ADDR_W + 1;
   localparam logic [ADDR_W:0] DEPTH_C = CW'(DEPTH);
   localparam logic [ADDR_W:0] AF_C    = CW'(AF_THRESH);
   localparam logic [ADDR_W:0] AE_C    = CW'(AE_THRESH);

   if (!fifo_cfg_ok(DEPTH, AE_THRESH, AF_THRESH)) begin : g_cfg_err
      $error("syn_fifo_param: bad DEPTH or threshold setting");
   end

   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count_nxt;
   logic              rd_accept;
   logic              wr_accept;

   assign rd_accept = rd_en && !fifo_empty;
   // A full FIFO still takes a write when a read frees a slot.
   assign wr_accept = wr_en && (!fifo_full || rd_accept);

   always_comb begin
      count_nxt = data_count;
      unique case ({wr_accept, rd_accept})
         2'b10:   count_nxt = data_count + CW'(1);
         2'b01:   count_nxt = data_count - CW'(1);
         default: count_nxt = data_count;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         data_count   <= '0;
         fifo_full    <= 1'b0;
         fifo_empty   <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         if (wr_accept) wr_ptr <= wr_ptr + ADDR_W'(1);
         if (rd_accept) rd_ptr <= rd_ptr + ADDR_W'(1);
         data_count   <= count_nxt;
         fifo_full    <= (count_nxt == DEPTH_C);
         fifo_empty   <= (count_nxt == '0);
         almost_full  <= (count_nxt >= AF_C);
         almost_empty <= (count_nxt <= AE_C);
         overflow     <= wr_en && !wr_accept;
         underflow    <= rd_en && !rd_accept;
      end
   end

   fifo_ram_dp #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .REG_RD (!FWFT)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_accept),
      .waddr (wr_ptr),
      .wdata (wr_data),
      .re    (rd_accept),
      .raddr (rd_ptr),
      .rdata (rd_data)
   );

   if (FWFT) begin : g_fwft
      assign rd_valid = !fifo_empty;
   end else begin : g_std
      always_ff @(posedge clk or posedge rst) begin
         if (rst) rd_valid <= 1'b0;
         else     rd_valid <= rd_accept;
      end
   end

endmodule
